axi_slave_ram: RTL and testbench
================================

# axi_slave_ram

AXI3 slave memory model: the responder on the other end of the CPU-side AXI master. Single-ported word array behind independent read and write channels. Each channel has one outstanding transaction. FIXED and INCR bursts of 1–16 beats are supported. It sits behind the master or crossbar in SoC-level simulation and FPGA bring-up, standing in for inst/data RAM.

## Interface
- `ADDR_W`, default 14: word-address width; memory holds 2^ADDR_W 32-bit words.
- `INIT_FILE`, default "": hex image loaded with `$readmemh` when non-empty.
- `aclk`, in, 1: clock; every register updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `arid`, in, 4: read request ID.
- `araddr`, in, 32: read byte address.
- `arlen`, in, 4: beats minus one.
- `arsize`, in, 3: log2 bytes per beat; must be 0–2.
- `arburst`, in, 2: 00 FIXED, 01 INCR, other values are treated as INCR.
- `arlock`, in, 2; `arcache`, in, 4; `arprot`, in, 3: ignored.
- `arvalid`, in, 1; `arready`, out, 1: read address handshake.
- `rid`, out, 4; `rdata`, out, 32; `rresp`, out, 2 (always 00); `rlast`, out, 1.
- `rvalid`, out, 1; `rready`, in, 1: read data handshake.
- `awid`, in, 4; `awaddr`, in, 32; `awlen`, in, 4; `awsize`, in, 3; `awburst`, in, 2: same meaning as the read side.
- `awlock`, in, 2; `awcache`, in, 4; `awprot`, in, 3: ignored.
- `awvalid`, in, 1; `awready`, out, 1: write address handshake.
- `wid`, in, 4: ignored; beats are associated with the accepted AW.
- `wdata`, in, 32; `wstrb`, in, 4; `wlast`, in, 1.
- `wvalid`, in, 1; `wready`, out, 1: write data handshake.
- `bid`, out, 4; `bresp`, out, 2 (always 00).
- `bvalid`, out, 1; `bready`, in, 1: write response handshake.

## Operation
- **Read FSM: RD_IDLE → RD_DATA → RD_IDLE.**
  - RD_IDLE: `arready`=1. On arvalid&arready, latch id, addr, len, size, burst; zero the beat counter; go to RD_DATA.
  - RD_DATA: `rvalid`=1. `rdata` = mem[addr[ADDR_W+1:2]]. `rlast` = (beat == len).
  - On rvalid&rready with !rlast: addr += (1<<size) for INCR, unchanged for FIXED; beat++.
  - On rvalid&rready with rlast: return to RD_IDLE.
  - `rvalid` and `rdata` hold stable while `rready`=0.
- **Write FSM: WR_IDLE → WR_DATA → WR_RESP → WR_IDLE.**
  - WR_IDLE: `awready`=1. On handshake, latch id, addr, size, burst; go to WR_DATA. W beats are not accepted before AW.
  - WR_DATA: `wready`=1. On wvalid&wready, write byte i of mem[addr[ADDR_W+1:2]] where wstrb[i]=1, then advance addr as on the read side.
  - Beat count is not checked against awlen; `wlast` alone ends the burst and moves to WR_RESP.
  - WR_RESP: `bvalid`=1, `bid` = latched awid. On bready, return to WR_IDLE.
- **Addressing:**
  - Bits above ADDR_W+1 are ignored, so accesses wrap modulo memory size.
  - Bytes are not lane-shifted for narrow sizes. The master selects lanes via wstrb and extracts read lanes itself.
  - Address increment is a 32-bit add.
- **Read/write same word, same cycle:** the write commits at the edge and the read beat shows old data that cycle. The read-data mux is combinational from the array, so the next cycle shows new data if the beat is still pending.
- **Reset mid-burst:** both FSMs return to idle and the burst is abandoned with no response. Memory contents are retained.

## Timing
- **Reset values:** arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rid=0, bid=0, rresp=0, bresp=0. The ready signals rise the first cycle after reset deasserts.
- **Read latency:** AR handshake at cycle T gives first `rvalid` at T+1. Beats are back-to-back at one per cycle while rready=1. `arready` returns at the cycle after the rlast handshake.
- **Write latency:**
  - AW handshake at T gives `wready` at T+1.
  - The wlast handshake at cycle U gives `bvalid` at U+1.
  - `awready` returns the cycle after the B handshake.
- **Channel independence:** read and write channels run fully concurrently.

## Configuration
- `AXI_SLAVE_RAND_STALL_EN`:
  - **Defined:** a 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. Bit 0 gates `arready` and `awready`; bit 1 gates `wready`; bit 2 gates `rvalid`.
  - Gating only deasserts a signal. `rvalid` is never dropped once asserted until its handshake completes. The gate is sampled only when rvalid would newly rise.
  - **Undefined:** no LFSR, no gating; timing is exactly as above.

## Test plan
- **Single read:** preload mem[0x10]=32'hDEADBEEF; AR addr 0x40, len 0, id 3 → rvalid at T+1 with rdata DEADBEEF, rid 3, rlast 1, rresp 0.
- **INCR write with backpressure:** AW addr 0x100, len 3, id 1, then 4 W beats 1,2,3,4 with wstrb F and wlast on beat 4, bready held low 3 cycles → bvalid stays high, bid 1; a later read of words 0x40–0x43 returns 1,2,3,4.
- **Partial strobe:** word = 0x11223344, write 0xAABBCCDD with wstrb 0101 → reads 0x11BB33DD.
- **FIXED read, rready toggling:** len 2, burst 00 → three beats of the same word; rlast only on beat 3; rdata stable while rready=0.
- **Concurrent channels:** read len 7 overlapping a write len 7 at a different address → both complete; no beat lost or duplicated.
- **Reset mid-burst:** reset at read beat 2 of 8 → rvalid=0 next cycle; a new AR then completes correctly; memory is unchanged.

Source files
------------

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI3 slave word RAM, one outstanding burst per channel, FIXED/INCR 1-16 beats.
module axi_slave_ram #(
  parameter int    ADDR_W    = 14,
  parameter string INIT_FILE = ""
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  rd_state_t rd_st, rd_nx;
  wr_state_t wr_st, wr_nx;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] r_addr, w_addr;
  logic [3:0] r_len, r_beat;
  logic [2:0] r_size, w_size;
  logic [1:0] r_burst, w_burst;
  logic live, a_go, w_go, r_go;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic unused_ok;
  function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return bu == 2'b00 ? a : a + (32'd1 << sz);
  endfunction
`ifdef AXI_SLAVE_RAND_STALL_EN
  logic [15:0] lfsr;
  logic r_hold;
  always_ff @(posedge aclk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
      r_hold <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      r_hold <= rvalid && !rready;
    end
  end
  assign a_go = lfsr[0];
  assign w_go = lfsr[1];
  assign r_go = r_hold || lfsr[2];
`else
  assign a_go = 1'b1;
  assign w_go = 1'b1;
  assign r_go = 1'b1;
`endif
  always_ff @(posedge aclk) begin
    if (reset) begin
      live <= 1'b0;
      rd_st <= RD_IDLE;
      wr_st <= WR_IDLE;
      rid <= '0;
      bid <= '0;
    end else begin
      live <= 1'b1;
      rd_st <= rd_nx;
      wr_st <= wr_nx;
      if (ar_hs) rid <= arid;
      if (aw_hs) bid <= awid;
    end
  end
  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      r_addr <= araddr;
      r_len <= arlen;
      r_size <= arsize;
      r_burst <= arburst;
      r_beat <= '0;
    end else if (r_hs) begin
      r_addr <= step(r_addr, r_size, r_burst);
      r_beat <= r_beat + 4'd1;
    end
    if (aw_hs) begin
      w_addr <= awaddr;
      w_size <= awsize;
      w_burst <= awburst;
    end else if (w_hs) begin
      w_addr <= step(w_addr, w_size, w_burst);
    end
  end
  always_ff @(posedge aclk) begin
    for (int i = 0; i < 4; i++)
      if (w_hs && wstrb[i]) mem[w_addr[ADDR_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_comb begin
    arready = live && rd_st == RD_IDLE && a_go;
    rvalid = rd_st == RD_DATA && r_go;
    rlast = rd_st == RD_DATA && r_beat == r_len;
    ar_hs = arvalid && arready;
    r_hs = rvalid && rready;
    rd_nx = rd_st == RD_IDLE ? (ar_hs ? RD_DATA : RD_IDLE) : (r_hs && rlast ? RD_IDLE : RD_DATA);
  end
  always_comb begin
    awready = live && wr_st == WR_IDLE && a_go;
    wready = wr_st == WR_DATA && w_go;
    bvalid = wr_st == WR_RESP;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    b_hs = bvalid && bready;
    wr_nx = wr_st == WR_IDLE ? (aw_hs ? WR_DATA : WR_IDLE)
          : wr_st == WR_DATA ? (w_hs && wlast ? WR_RESP : WR_DATA)
          : (b_hs ? WR_IDLE : WR_RESP);
  end
  assign rdata = mem[r_addr[ADDR_W+1:2]];
  assign rresp = 2'b00;
  assign bresp = 2'b00;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       r_addr[31:ADDR_W+2], r_addr[1:0], w_addr[31:ADDR_W+2], w_addr[1:0]};
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: directed table, hand sequences and random bursts against a word-array model.
module tb_axi_slave_ram;
   localparam int AW = 14;
   localparam int NW = 1 << AW;
   logic aclk = 1'b0, reset = 1'b1;
   logic [3:0] arid = '0, arlen = '0, arcache = '0, awid = '0, awlen = '0, awcache = '0, wid = '0, wstrb = '0;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic [2:0] arsize = '0, arprot = '0, awsize = '0, awprot = '0;
   logic [1:0] arburst = '0, arlock = '0, awburst = '0, awlock = '0;
   logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic arready, rlast, rvalid, awready, wready, bvalid;
   logic [3:0] rid, bid;
   logic [31:0] rdata;
   logic [1:0] rresp, bresp;
   int errors = 0, checks = 0;
   logic [31:0] mdl [NW];
   logic [31:0] wbuf [16];
   logic [3:0] sbuf [16];
   logic [31:0] rgot [16];
   typedef struct {
      logic [31:0] init;
      logic [31:0] wd;
      logic [3:0]  st;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [5];

   axi_slave_ram #(.ADDR_W(AW)) dut (
      .aclk(aclk), .reset(reset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   initial begin
      #900000;
      $display("FAIL watchdog expired: got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h required=%h at %0t", nm, got, exp, $time);
      end
   endtask

   // word touched by beat i: FIXED repeats the start address, anything else strides by 2^size bytes
   function automatic int widx(input logic [31:0] a, input int i, input logic [2:0] sz, input logic [1:0] bu);
      logic [31:0] b;
      b = bu == 2'b00 ? a : a + 32'(i) * (32'd1 << sz);
      return int'(b[AW+1:2]);
   endfunction

   task automatic do_write(input logic [31:0] a, input int n, input logic [3:0] al, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [3:0] id, input int bst);
      int t, idx;
      chk("wready_idle", 32'(wready), 0);
      awaddr = a; awlen = al; awsize = sz; awburst = bu; awid = id; awvalid = 1'b1;
      t = 0;
      while (!awready && t < 50) begin @(posedge aclk); #1; t++; end
      chk("aw_ready", 32'(awready), 1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      chk("wready_lat", 32'(wready), 1);
      for (int i = 0; i < n; i++) begin
         wdata = wbuf[i]; wstrb = sbuf[i]; wlast = i == n - 1; wvalid = 1'b1;
         t = 0;
         while (!wready && t < 50) begin @(posedge aclk); #1; t++; end
         chk("w_ready", 32'(wready), 1);
         @(posedge aclk); #1;
         idx = widx(a, i, sz, bu);
         for (int k = 0; k < 4; k++)
            if (sbuf[i][k]) mdl[idx][8*k +: 8] = wbuf[i][8*k +: 8];
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("bvalid_lat", 32'(bvalid), 1);
      chk("bid", 32'(bid), 32'(id));
      chk("bresp", 32'(bresp), 0);
      for (int s = 0; s < bst; s++) begin
         @(posedge aclk); #1;
         chk("b_hold", 32'(bvalid), 1);
         chk("bid_hold", 32'(bid), 32'(id));
      end
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      chk("b_done", 32'(bvalid), 0);
      chk("aw_return", 32'(awready), 1);
   endtask

   task automatic do_read(input logic [31:0] a, input int n, input logic [2:0] sz, input logic [1:0] bu,
                          input logic [3:0] id, input int mode);
      int t, st, idx;
      araddr = a; arlen = 4'(n - 1); arsize = sz; arburst = bu; arid = id; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 50) begin @(posedge aclk); #1; t++; end
      chk("ar_ready", 32'(arready), 1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      for (int i = 0; i < n; i++) begin
         idx = widx(a, i, sz, bu);
         chk("rvalid", 32'(rvalid), 1);
         chk("rdata", rdata, mdl[idx]);
         chk("rid", 32'(rid), 32'(id));
         chk("rlast", 32'(rlast), 32'(i == n - 1));
         chk("rresp", 32'(rresp), 0);
         rgot[i] = rdata;
         st = mode == 1 ? 1 : mode == 2 ? $urandom_range(0, 2) : 0;
         for (int s = 0; s < st; s++) begin
            @(posedge aclk); #1;
            chk("r_hold", 32'(rvalid), 1);
            chk("r_stable", rdata, rgot[i]);
         end
         rready = 1'b1;
         @(posedge aclk); #1;
         rready = 1'b0;
      end
      chk("r_done", 32'(rvalid), 0);
      chk("ar_return", 32'(arready), 1);
   endtask

   initial begin
      logic [31:0] ra, wa;
      int n;
      tbl[0] = '{32'h11223344, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
      tbl[1] = '{32'h11223344, 32'hAABBCCDD, 4'b1010, 32'hAA22CC44};
      tbl[2] = '{32'h00000000, 32'hFFFFFFFF, 4'b0000, 32'h00000000};
      tbl[3] = '{32'h12345678, 32'h9ABCDEF0, 4'b1111, 32'h9ABCDEF0};
      tbl[4] = '{32'h12345678, 32'h9ABCDEF0, 4'b1000, 32'h9A345678};
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_arready", 32'(arready), 0);
      chk("rst_awready", 32'(awready), 0);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rlast", 32'(rlast), 0);
      chk("rst_rid", 32'(rid), 0);
      chk("rst_bid", 32'(bid), 0);
      chk("rst_rresp", 32'(rresp), 0);
      chk("rst_bresp", 32'(bresp), 0);
      reset = 1'b0;
      chk("rdy_pre", 32'(arready), 0);
      @(posedge aclk); #1;
      chk("rdy_post_ar", 32'(arready), 1);
      chk("rdy_post_aw", 32'(awready), 1);
      // give every word a known value so any later read is checkable
      for (int b = 0; b < NW / 16; b++) begin
         for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
         do_write(32'(b * 64), 16, 4'd15, 3'd2, 2'b01, 4'(b), 0);
      end
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      do_write(32'h40, 1, 4'd0, 3'd2, 2'b01, 4'd2, 0);
      do_read(32'h40, 1, 3'd2, 2'b01, 4'd3, 0);
      chk("single_read", rgot[0], 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
      do_write(32'h100, 4, 4'd3, 3'd2, 2'b01, 4'd1, 3);
      do_read(32'h100, 4, 3'd2, 2'b01, 4'd6, 0);
      for (int i = 0; i < 4; i++) chk("incr_word", rgot[i], 32'(i + 1));
      for (int v = 0; v < 5; v++) begin
         wbuf[0] = tbl[v].init; sbuf[0] = 4'hF;
         do_write(32'h200, 1, 4'd0, 3'd2, 2'b01, 4'd4, 0);
         wbuf[0] = tbl[v].wd; sbuf[0] = tbl[v].st;
         do_write(32'h200, 1, 4'd0, 3'd2, 2'b01, 4'd4, 1);
         do_read(32'h200, 1, 3'd2, 2'b01, 4'd4, 0);
         chk("strobe", rgot[0], tbl[v].exp);
      end
      do_read(32'h200, 3, 3'd2, 2'b00, 4'd7, 1);
      chk("fixed_same", rgot[2], rgot[0]);
      wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(32'h0000FFFC, 2, 4'd1, 3'd2, 2'b01, 4'd8, 0);
      do_read(32'hABCD0000, 1, 3'd2, 2'b01, 4'd9, 0);
      chk("wrap", rgot[0], 32'hCAFE0002);
      for (int i = 0; i < 3; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(32'h400, 3, 4'd0, 3'd2, 2'b01, 4'd10, 0);
      do_read(32'h400, 3, 3'd2, 2'b01, 4'd10, 0);
      for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      fork
         do_write(32'h8000, 8, 4'd7, 3'd2, 2'b01, 4'd11, 1);
         do_read(32'h1000, 8, 3'd2, 2'b01, 4'd12, 2);
      join
      do_read(32'h8000, 8, 3'd2, 2'b01, 4'd13, 0);
      // abandon an 8-beat read in its third beat
      chk("rst_ar_ready", 32'(arready), 1);
      araddr = 32'h300; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'd5; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0; rready = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      rready = 1'b0;
      chk("mid_rvalid", 32'(rvalid), 1);
      chk("mid_rdata", rdata, mdl[widx(32'h300, 2, 3'd2, 2'b01)]);
      reset = 1'b1;
      @(posedge aclk); #1;
      chk("mid_rst_rvalid", 32'(rvalid), 0);
      chk("mid_rst_arready", 32'(arready), 0);
      reset = 1'b0;
      @(posedge aclk); #1;
      chk("mid_rst_back", 32'(arready), 1);
      do_read(32'h300, 8, 3'd2, 2'b01, 4'd5, 0);
      for (int it = 0; it < 200; it++) begin
         n = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
         case ($urandom_range(0, 2))
            0: do_write($urandom, n, 4'(n - 1), 3'($urandom_range(0, 2)), 2'($urandom), 4'($urandom), $urandom_range(0, 3));
            1: do_read($urandom, n, 3'($urandom_range(0, 2)), 2'($urandom), 4'($urandom), $urandom_range(0, 2));
            default: begin
               ra = {16'($urandom), 2'b00, 12'($urandom), 2'b00};
               wa = {16'($urandom), 2'b10, 12'($urandom), 2'b00};
               fork
                  do_write(wa, n, 4'(n - 1), 3'd2, 2'($urandom), 4'($urandom), $urandom_range(0, 2));
                  do_read(ra, 17 - n, 3'd2, 2'($urandom), 4'($urandom), $urandom_range(0, 2));
               join
            end
         endcase
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
